// File: rtl/adder_pkg.sv
// Shared constants, operation encoding and parameter checks for the pipelined adder.
package adder_pkg;

  localparam int unsigned CLA_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int unsigned seg_width(int unsigned dw, int unsigned stages);
    return (stages == 0) ? dw : dw / stages;
  endfunction

  function automatic bit params_ok(int unsigned dw, int unsigned stages, int unsigned tw);
    return (stages >= 1) && (stages <= dw / CLA_W) && ((dw % (CLA_W * stages)) == 0) &&
           (tw >= 1) && (tw <= 16);
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice with fully expanded carry terms.
module cla_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                  (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
                  (w_p[3] & w_p[2] & w_p[1] & w_g[0]) |
                  (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

// File: rtl/pipe_adder_seg.sv
// Combinational SEG-bit adder segment built from a ripple of 4-bit CLA slices.
module pipe_adder_seg
  import adder_pkg::*;
#(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_cmsb
);

  localparam int unsigned NSL = SEG / CLA_W;

  logic [NSL:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < NSL; i++) begin : g_slice
    cla_4bit u_cla (
      .i_a   (i_a[i*CLA_W +: CLA_W]),
      .i_b   (i_b[i*CLA_W +: CLA_W]),
      .i_cin (w_c[i]),
      .o_sum (o_sum[i*CLA_W +: CLA_W]),
      .o_cout(w_c[i+1])
    );
  end

  assign o_cout = w_c[NSL];
  // Carry into the top bit recovered from its sum and operand bits.
  assign o_cmsb = o_sum[SEG-1] ^ i_a[SEG-1] ^ i_b[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: carry chain split into STAGES registered segments with
// valid/ready flow control; each stage register doubles as the skid for backpressure.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_cin,
  input  logic          in_sub,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sum,
  output logic          out_cout,
  output logic          out_ovf,
  output logic [TW-1:0] out_tag
);

  localparam int unsigned SEG = seg_width(DW, STAGES);

  if (!params_ok(DW, STAGES, TW)) begin : g_bad_params
    $error("pipe_adder: illegal DW/STAGES/TW combination");
  end

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [DW-1:0]     r_a   [STAGES];
  logic [DW-1:0]     r_b   [STAGES];
  logic [DW-1:0]     r_s   [STAGES];
  logic [TW-1:0]     r_tag [STAGES];
  logic              r_ovf;

  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_ci;
  logic [STAGES-1:0] w_co;
  logic [STAGES-1:0] w_cm;
  logic [DW-1:0]     w_a   [STAGES];
  logic [DW-1:0]     w_b   [STAGES];
  logic [DW-1:0]     w_sp  [STAGES];
  logic [DW-1:0]     w_sn  [STAGES];
  logic [TW-1:0]     w_tag [STAGES];
  logic [SEG-1:0]    w_seg [STAGES];
  logic              w_unused_cm;
  op_t               w_op;

  assign w_op          = op_t'(in_sub);
  assign w_rdy[STAGES] = out_ready;
  // Only the last segment's carry-into-MSB feeds the overflow flag.
  assign w_unused_cm   = ^w_cm;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign w_rdy[k] = !r_v[k] || w_rdy[k+1];

    if (k == 0) begin : g_first
      assign w_vin[k] = in_valid;
      assign w_a[k]   = in_a;
      assign w_b[k]   = (w_op == OP_SUB) ? ~in_b : in_b;
      assign w_ci[k]  = (w_op == OP_SUB) ? 1'b1 : in_cin;
      assign w_sp[k]  = '0;
      assign w_tag[k] = in_tag;
    end else begin : g_next
      assign w_vin[k] = r_v[k-1];
      assign w_a[k]   = r_a[k-1];
      assign w_b[k]   = r_b[k-1];
      assign w_ci[k]  = r_c[k-1];
      assign w_sp[k]  = r_s[k-1];
      assign w_tag[k] = r_tag[k-1];
    end

    pipe_adder_seg #(
      .SEG(SEG)
    ) u_seg (
      .i_a   (w_a[k][k*SEG +: SEG]),
      .i_b   (w_b[k][k*SEG +: SEG]),
      .i_cin (w_ci[k]),
      .o_sum (w_seg[k]),
      .o_cout(w_co[k]),
      .o_cmsb(w_cm[k])
    );

    // Upper bits of the partial sum are still zero, so OR merges the new segment.
    assign w_sn[k] = w_sp[k] | (DW'(w_seg[k]) << (k * SEG));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[k]   <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_tag[k] <= '0;
      end else if (w_rdy[k]) begin
        r_v[k] <= w_vin[k];
        if (w_vin[k]) begin
          r_c[k]   <= w_co[k];
          r_a[k]   <= w_a[k];
          r_b[k]   <= w_b[k];
          r_s[k]   <= w_sn[k];
          r_tag[k] <= w_tag[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_rdy[STAGES-1] && w_vin[STAGES-1]) begin
      r_ovf <= w_co[STAGES-1] ^ w_cm[STAGES-1];
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[STAGES-1];
  assign out_sum   = r_s[STAGES-1];
  assign out_cout  = r_c[STAGES-1];
  assign out_ovf   = r_ovf;
  assign out_tag   = r_tag[STAGES-1];

endmodule
